// File: rtl/bbpd_loop_filter_if.sv
// rtl/bbpd_loop_filter_if.sv - vote/control and PI-code bundle between phase detector and loop filter
interface bbpd_loop_filter_if #(
    parameter int PI_WIDTH  = 8,
    parameter int INT_WIDTH = 12
);
    logic                        en;
    logic                        up;
    logic                        dn;
    logic                        freeze;
    logic [PI_WIDTH-1:0]         pi_code;
    logic                        pi_valid;
    logic signed [INT_WIDTH-1:0] integ;
    logic                        integ_sat;

    modport master (
        output en, up, dn, freeze,
        input  pi_code, pi_valid, integ, integ_sat
    );

    modport slave (
        input  en, up, dn, freeze,
        output pi_code, pi_valid, integ, integ_sat
    );
endinterface

// File: rtl/bbpd_loop_filter.sv
// rtl/bbpd_loop_filter.sv - bang-bang CDR loop filter: vote decimation then PI update of a circular phase accumulator
module bbpd_loop_filter #(
    parameter int PI_WIDTH   = 8,
    parameter int FRAC_WIDTH = 4,
    parameter int INT_WIDTH  = 12,
    parameter int DECIM      = 4,
    parameter int KP         = 16,
    parameter int KI         = 1
) (
    input logic              clk,
    input logic              rst_n,
    bbpd_loop_filter_if.slave bus
);
    localparam int ACC_W = PI_WIDTH + FRAC_WIDTH;
    localparam int VS_W  = $clog2(DECIM) + 2;
    localparam int CNT_W = $clog2(DECIM);
    localparam int SUM_W = (ACC_W > INT_WIDTH) ? ACC_W : INT_WIDTH;
    localparam int IW2   = INT_WIDTH + 2;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [SUM_W-1:0] KP_X   = SUM_W'(KP);
    localparam logic signed [IW2-1:0]   KI_X   = IW2'(KI);
    localparam logic signed [IW2-1:0]   IMAX_X = IW2'((2 ** (INT_WIDTH - 1)) - 1);

    logic signed [VS_W-1:0]      vote_sum_q, vote_sum_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        dec_v_q, dec_v_d;
    logic signed [1:0]           dec_r_q, dec_r_d;
    logic [ACC_W-1:0]            phase_acc_q, phase_acc_d;
    logic signed [INT_WIDTH-1:0] integ_q, integ_d;
    logic                        pi_valid_q, pi_valid_d;
    logic                        integ_sat_q, integ_sat_d;

    logic signed [1:0]      vote;
    logic signed [VS_W-1:0] sum_full;
    logic signed [SUM_W-1:0] kp_step, integ_sx, phase_sum;
    logic signed [IW2-1:0]  ki_step, integ_sum;

    always_comb begin
        vote = 2'sb00;
        if (bus.up && !bus.dn) vote = 2'sb01;
        else if (bus.dn && !bus.up) vote = 2'sb11;
        sum_full = vote_sum_q + VS_W'(vote);
    end

    // Stage 1: accumulate DECIM enabled votes, then emit the sign as one decision
    always_comb begin
        vote_sum_d = vote_sum_q;
        cnt_d      = cnt_q;
        dec_v_d    = 1'b0;
        dec_r_d    = dec_r_q;
        if (bus.en) begin
            if (cnt_q == CNT_LAST) begin
                if (sum_full > 0)      dec_r_d = 2'sb01;
                else if (sum_full < 0) dec_r_d = 2'sb11;
                else                   dec_r_d = 2'sb00;
                dec_v_d    = 1'b1;
                vote_sum_d = '0;
                cnt_d      = '0;
            end else begin
                vote_sum_d = sum_full;
                cnt_d      = cnt_q + 1'b1;
            end
        end
    end

    // Stage 2: phase uses the pre-update integral; phase wraps, integral clamps symmetrically
    always_comb begin
        kp_step   = (dec_r_q == 2'sb01) ? KP_X : (dec_r_q == 2'sb11) ? -KP_X : '0;
        ki_step   = (dec_r_q == 2'sb01) ? KI_X : (dec_r_q == 2'sb11) ? -KI_X : '0;
        integ_sx  = SUM_W'(integ_q);
        phase_sum = SUM_W'(phase_acc_q) + kp_step + integ_sx;
        integ_sum = IW2'(integ_q) + ki_step;

        phase_acc_d = phase_acc_q;
        integ_d     = integ_q;
        integ_sat_d = integ_sat_q;
        pi_valid_d  = 1'b0;
        if (dec_v_q) begin
            phase_acc_d = phase_sum[ACC_W-1:0];
            pi_valid_d  = 1'b1;
            if (!bus.freeze) begin
                if (integ_sum > IMAX_X) begin
                    integ_d     = IMAX_X[INT_WIDTH-1:0];
                    integ_sat_d = 1'b1;
                end else if (integ_sum < -IMAX_X) begin
                    integ_d     = -IMAX_X[INT_WIDTH-1:0];
                    integ_sat_d = 1'b1;
                end else begin
                    integ_d = integ_sum[INT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_sum_q  <= '0;
            cnt_q       <= '0;
            dec_v_q     <= 1'b0;
            dec_r_q     <= 2'sb00;
            phase_acc_q <= '0;
            integ_q     <= '0;
            pi_valid_q  <= 1'b0;
            integ_sat_q <= 1'b0;
        end else begin
            vote_sum_q  <= vote_sum_d;
            cnt_q       <= cnt_d;
            dec_v_q     <= dec_v_d;
            dec_r_q     <= dec_r_d;
            phase_acc_q <= phase_acc_d;
            integ_q     <= integ_d;
            pi_valid_q  <= pi_valid_d;
            integ_sat_q <= integ_sat_d;
        end
    end

    assign bus.pi_code   = phase_acc_q[ACC_W-1:FRAC_WIDTH];
    assign bus.pi_valid  = pi_valid_q;
    assign bus.integ     = integ_q;
    assign bus.integ_sat = integ_sat_q;
endmodule
